// File: rtl/bullet_collision_scanner.sv
// bullet_collision_scanner
// Walks every bullet slot once per start pulse, latches the slot geometry,
// and tests it against the heart bounding box. Each hit raises is_collide
// while index still points at the slot, so the bullet table can clear that
// slot's render bit. Hits also drain a saturating HP counter. After a
// damaging hit, further hits deal no damage for a few scans.
module bullet_collision_scanner #(
    parameter int          NUM_BULLETS  = 3,      // slots 0..NUM_BULLETS-1, at most 8
    parameter logic [7:0]  HP_INIT      = 8'd100,
    parameter logic [7:0]  DAMAGE       = 8'd10,
    parameter logic [3:0]  INVULN_SCANS = 4'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] heart_pos,
    input  logic [15:0] heart_size,
    output logic [2:0]  index,
    input  logic [15:0] bullet_pos,
    input  logic [15:0] bullet_size,
    input  logic        bullet_render,
    output logic        is_collide,
    output logic [7:0]  hp,
    output logic        dead,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CHECK = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [2:0] LAST_SLOT = 3'(NUM_BULLETS - 1);

    state_t      state_q, state_d;
    logic [2:0]  slot_q, slot_d;

    // Geometry captured during FETCH so CHECK works on a stable snapshot.
    logic [15:0] bpos_q, bpos_d;
    logic [15:0] bsize_q, bsize_d;
    logic        brender_q, brender_d;
    logic [15:0] hpos_q, hpos_d;
    logic [15:0] hsize_q, hsize_d;

    logic [7:0]  hp_q, hp_d;
    logic        dead_q, dead_d;
    logic [3:0]  invuln_q, invuln_d;
    // Set when the current scan dealt damage. That scan does not count
    // toward the invulnerability window. The window covers the next
    // INVULN_SCANS full scans.
    logic        dmg_scan_q, dmg_scan_d;

    logic [1:0]  axis_ok;
    logic        hit;
    logic [7:0]  hp_after_hit;

    // Per-axis overlap test on the latched snapshot. gi = 1 is x, gi = 0 is y.
    // The far edges are formed in 9 bits, so a box that runs past 255 does
    // not wrap around to small coordinates. The comparisons are strict, so
    // edges that only touch do not count as an overlap.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic [8:0] b_lo, b_hi, h_lo, h_hi;
            logic       b_len_nz, h_len_nz;

            assign b_lo     = {1'b0, bpos_q[gi*8 +: 8]};
            assign h_lo     = {1'b0, hpos_q[gi*8 +: 8]};
            assign b_hi     = b_lo + {1'b0, bsize_q[gi*8 +: 8]};
            assign h_hi     = h_lo + {1'b0, hsize_q[gi*8 +: 8]};
            assign b_len_nz = |bsize_q[gi*8 +: 8];
            assign h_len_nz = |hsize_q[gi*8 +: 8];

            assign axis_ok[gi] = b_len_nz && h_len_nz && (b_lo < h_hi) && (h_lo < b_hi);
        end
    endgenerate

    assign hit          = brender_q && (&axis_ok);
    assign hp_after_hit = (hp_q > DAMAGE) ? (hp_q - DAMAGE) : 8'd0;

    // Next-state logic: sequencing of the slot walk, latching, damage and invulnerability.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        bpos_d     = bpos_q;
        bsize_d    = bsize_q;
        brender_d  = brender_q;
        hpos_d     = hpos_q;
        hsize_d    = hsize_q;
        hp_d       = hp_q;
        dead_d     = dead_q;
        invuln_d   = invuln_q;
        dmg_scan_d = dmg_scan_q;

        case (state_q)
            S_IDLE: begin
                if (start && !dead_q) begin
                    state_d    = S_FETCH;
                    slot_d     = 3'd0;
                    dmg_scan_d = 1'b0;
                end
            end

            S_FETCH: begin
                bpos_d    = bullet_pos;
                bsize_d   = bullet_size;
                brender_d = bullet_render;
                hpos_d    = heart_pos;
                hsize_d   = heart_size;
                state_d   = S_CHECK;
            end

            S_CHECK: begin
                // A hit during invulnerability still consumes the bullet.
                // It only skips the damage.
                if (hit && (invuln_q == 4'd0)) begin
                    hp_d       = hp_after_hit;
                    dead_d     = dead_q | (hp_after_hit == 8'd0);
                    invuln_d   = INVULN_SCANS;
                    dmg_scan_d = 1'b1;
                end
                if (slot_q == LAST_SLOT) begin
                    state_d = S_FIN;
                end else begin
                    slot_d  = slot_q + 3'd1;
                    state_d = S_FETCH;
                end
            end

            S_FIN: begin
                if ((invuln_q != 4'd0) && !dmg_scan_q) begin
                    invuln_d = invuln_q - 4'd1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            slot_q     <= 3'd0;
            bpos_q     <= 16'd0;
            bsize_q    <= 16'd0;
            brender_q  <= 1'b0;
            hpos_q     <= 16'd0;
            hsize_q    <= 16'd0;
            hp_q       <= HP_INIT;
            dead_q     <= 1'b0;
            invuln_q   <= 4'd0;
            dmg_scan_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            bpos_q     <= bpos_d;
            bsize_q    <= bsize_d;
            brender_q  <= brender_d;
            hpos_q     <= hpos_d;
            hsize_q    <= hsize_d;
            hp_q       <= hp_d;
            dead_q     <= dead_d;
            invuln_q   <= invuln_d;
            dmg_scan_q <= dmg_scan_d;
        end
    end

    // The outputs are decoded only from registers. index holds for the whole
    // FETCH+CHECK pair, so a clear always targets the slot that was tested.
    assign index      = slot_q;
    assign is_collide = (state_q == S_CHECK) && hit;
    assign busy       = (state_q == S_FETCH) || (state_q == S_CHECK);
    assign done       = (state_q == S_FIN);
    assign hp         = hp_q;
    assign dead       = dead_q;

endmodule

// File: tb/tb_bullet_collision_scanner.sv
// Directed bench for bullet_collision_scanner. Instance a uses the default
// parameters. Instance b uses HP_INIT = 15 and INVULN_SCANS = 0 for the
// saturation and death case. A small bullet table model drives the slot
// inputs from each instance's index.
`timescale 1ns/1ps
module tb_bullet_collision_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, start_b;
    logic [15:0] heart_pos, heart_size;

    logic [15:0] tbl_pos    [0:7];
    logic [15:0] tbl_size   [0:7];
    logic        tbl_render [0:7];

    logic [2:0]  idx_a, idx_b;
    logic [15:0] bpos_a, bsize_a, bpos_b, bsize_b;
    logic        brnd_a, brnd_b;
    logic        coll_a, coll_b, dead_a, dead_b, busy_a, busy_b, done_a, done_b;
    logic [7:0]  hp_a, hp_b;

    assign bpos_a  = tbl_pos[idx_a];
    assign bsize_a = tbl_size[idx_a];
    assign brnd_a  = tbl_render[idx_a];
    assign bpos_b  = tbl_pos[idx_b];
    assign bsize_b = tbl_size[idx_b];
    assign brnd_b  = tbl_render[idx_b];

    bullet_collision_scanner dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .heart_pos(heart_pos), .heart_size(heart_size),
        .index(idx_a), .bullet_pos(bpos_a), .bullet_size(bsize_a),
        .bullet_render(brnd_a), .is_collide(coll_a), .hp(hp_a),
        .dead(dead_a), .busy(busy_a), .done(done_a)
    );

    bullet_collision_scanner #(
        .NUM_BULLETS(3), .HP_INIT(8'd15), .DAMAGE(8'd10), .INVULN_SCANS(4'd0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .heart_pos(heart_pos), .heart_size(heart_size),
        .index(idx_b), .bullet_pos(bpos_b), .bullet_size(bsize_b),
        .bullet_render(brnd_b), .is_collide(coll_b), .hp(hp_b),
        .dead(dead_b), .busy(busy_b), .done(done_b)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] coll_m, busy_m, done_m;
    logic [2:0]  coll_idx;
    logic [7:0]  exp_hp [0:3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-24s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_slot(input int s, input logic [15:0] p, input logic [15:0] z, input logic r);
        tbl_pos[s]    = p;
        tbl_size[s]   = z;
        tbl_render[s] = r;
    endtask

    task automatic clear_table();
        for (int s = 0; s < 8; s++) set_slot(s, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulse start during cycle 0. Cycle c is the period after edge c-1.
    // Sample at mid-cycle for cycles 1..ncyc and record per-cycle masks.
    // extra_start > 0 injects a second start in that cycle. rst_cyc > 0
    // pulls rst_n low from that cycle onward.
    task automatic scan(input bit sel, input int extra_start, input int rst_cyc, input int ncyc);
        coll_m   = '0;
        busy_m   = '0;
        done_m   = '0;
        coll_idx = '0;
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if (sel ? coll_b : coll_a) begin
                coll_m[c] = 1'b1;
                coll_idx  = sel ? idx_b : idx_a;
            end
            if (sel ? busy_b : busy_a) busy_m[c] = 1'b1;
            if (sel ? done_b : done_a) done_m[c] = 1'b1;
            if (c == rst_cyc) rst_n = 1'b0;
            if (c == extra_start) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        rst_n   = 1'b1;
        $display("scan dut=%0d coll=0x%0h busy=0x%0h done=0x%0h idx=%0d", sel, coll_m, busy_m, done_m, coll_idx);
    endtask

    initial begin
        rst_n      = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        heart_pos  = 16'h5050;
        heart_size = 16'h1010;
        clear_table();
        exp_hp[0] = 8'd90; exp_hp[1] = 8'd90; exp_hp[2] = 8'd90; exp_hp[3] = 8'd80;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hp", 32'(hp_a), 32'd100);
        check("rst_hp_b", 32'(hp_b), 32'd15);
        check("rst_dead", 32'(dead_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_collide", 32'(coll_a), 32'd0);
        check("rst_index", 32'(idx_a), 32'd0);
        rst_n = 1'b1;

        // Basic hit on slot 1
        set_slot(1, 16'h5858, 16'h0808, 1'b1);
        scan(1'b0, 0, 0, 10);
        check("basic_coll_cycles", coll_m, 32'h10);
        check("basic_coll_index", 32'(coll_idx), 32'd1);
        check("basic_done_cycle", done_m, 32'h80);
        check("basic_busy_cycles", busy_m, 32'h7E);
        check("basic_hp", 32'(hp_a), 32'd90);
        check("basic_dead", 32'(dead_a), 32'd0);
        do_reset();

        // Boundary: touching right edge, then one pixel of overlap
        clear_table();
        set_slot(0, 16'h6058, 16'h0808, 1'b1);
        scan(1'b0, 0, 0, 10);
        check("touch_x_coll", coll_m, 32'h0);
        check("touch_x_hp", 32'(hp_a), 32'd100);
        set_slot(0, 16'h5F58, 16'h0808, 1'b1);
        scan(1'b0, 0, 0, 10);
        check("overlap_x_coll", coll_m, 32'h4);
        check("overlap_x_index", 32'(coll_idx), 32'd0);
        check("overlap_x_hp", 32'(hp_a), 32'd90);
        do_reset();

        // Zero sizes and a top-edge touch never hit
        set_slot(0, 16'h5858, 16'h0008, 1'b1);
        scan(1'b0, 0, 0, 10);
        check("zero_bw_coll", coll_m, 32'h0);
        set_slot(0, 16'h5858, 16'h0800, 1'b1);
        scan(1'b0, 0, 0, 10);
        check("zero_bh_coll", coll_m, 32'h0);
        set_slot(0, 16'h5858, 16'h0808, 1'b1);
        heart_size = 16'h0010;
        scan(1'b0, 0, 0, 10);
        check("zero_hw_coll", coll_m, 32'h0);
        heart_size = 16'h1010;
        set_slot(0, 16'h5848, 16'h0808, 1'b1);
        scan(1'b0, 0, 0, 10);
        check("touch_y_coll", coll_m, 32'h0);
        check("zero_size_hp", 32'(hp_a), 32'd100);

        // No wrap past 255, then a genuine overlap near the right edge
        heart_pos = 16'hF850;
        set_slot(0, 16'h0258, 16'h0408, 1'b1);
        scan(1'b0, 0, 0, 10);
        check("nowrap_coll", coll_m, 32'h0);
        set_slot(0, 16'hFA58, 16'h0408, 1'b1);
        scan(1'b0, 0, 0, 10);
        check("edge_hit_coll", coll_m, 32'h4);
        check("edge_hit_hp", 32'(hp_a), 32'd90);
        heart_pos = 16'h5050;
        do_reset();

        // Invulnerability across consecutive scans
        clear_table();
        set_slot(2, 16'h5858, 16'h0808, 1'b1);
        for (int k = 0; k < 4; k++) begin
            scan(1'b0, 0, 0, 10);
            check($sformatf("invuln_coll_%0d", k + 1), coll_m, 32'h40);
            check($sformatf("invuln_hp_%0d", k + 1), 32'(hp_a), 32'(exp_hp[k]));
        end
        do_reset();

        // Three hits in one scan: all bullets consumed, damage once
        set_slot(0, 16'h5858, 16'h0808, 1'b1);
        set_slot(1, 16'h5252, 16'h0404, 1'b1);
        scan(1'b0, 0, 0, 10);
        check("multi_coll", coll_m, 32'h54);
        check("multi_hp", 32'(hp_a), 32'd90);
        do_reset();

        // Reset asserted during cycle 3 of a hitting scan
        clear_table();
        set_slot(1, 16'h5858, 16'h0808, 1'b1);
        scan(1'b0, 0, 3, 10);
        check("midrst_coll", coll_m, 32'h0);
        check("midrst_busy", busy_m, 32'hE);
        check("midrst_done", done_m, 32'h0);
        check("midrst_hp", 32'(hp_a), 32'd100);

        // Dropped start pulses while busy or in FIN; accepted right after FIN
        clear_table();
        scan(1'b0, 3, 0, 14);
        check("drop_busy_done", done_m, 32'h80);
        check("drop_busy_busy", busy_m, 32'h7E);
        scan(1'b0, 7, 0, 14);
        check("drop_fin_done", done_m, 32'h80);
        scan(1'b0, 8, 0, 20);
        check("back2back_done", done_m, 32'h8080);
        check("back2back_busy", busy_m, 32'h7E7E);

        // Saturation and death on instance b
        set_slot(1, 16'h5858, 16'h0808, 1'b1);
        scan(1'b1, 0, 0, 10);
        check("sat_hp_1", 32'(hp_b), 32'd5);
        check("sat_dead_1", 32'(dead_b), 32'd0);
        check("sat_coll_1", coll_m, 32'h10);
        scan(1'b1, 0, 0, 10);
        check("sat_hp_2", 32'(hp_b), 32'd0);
        check("sat_dead_2", 32'(dead_b), 32'd1);
        check("sat_done_2", done_m, 32'h80);
        scan(1'b1, 0, 0, 10);
        check("dead_busy", busy_m, 32'h0);
        check("dead_done", done_m, 32'h0);
        check("dead_coll", coll_m, 32'h0);
        check("dead_hold", 32'(dead_b), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
